// File: rtl/mips_bus_arbiter.sv
// Two-master, one-slave Avalon-style arbiter for a single shared RAM.
// Each grant carries exactly one transfer and is followed by one IDLE cycle of re-arbitration.
module mips_bus_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,

  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,

  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,

  output logic [1:0]  grant
);

  // state  | meaning
  // IDLE   | no owner; arbitrating among current requests
  // GRANT0 | master 0 owns the slave for one transfer
  // GRANT1 | master 1 owns the slave for one transfer
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  logic [1:0] state, state_next;
  logic       last_grant, last_grant_next;
  logic       req0, req1, done;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign done = (s_read | s_write) & ~s_waitrequest;

  // Read data is broadcast; only the owner's completion cycle makes it meaningful.
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    grant          = 2'b00;
    case (state)
      GRANT0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
        grant          = 2'b01;
      end
      GRANT1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
        grant          = 2'b10;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (req0 && req1)
          state_next = (FIXED_PRIORITY || last_grant) ? GRANT0 : GRANT1;
        else if (req0)
          state_next = GRANT0;
        else if (req1)
          state_next = GRANT1;
      end
      GRANT0: begin
        if (done) begin
          state_next      = IDLE;
          last_grant_next = 1'b0;
        end else if (!req0) begin
          // Owner abandoned its request; release without crediting it.
          state_next = IDLE;
        end
      end
      GRANT1: begin
        if (done) begin
          state_next      = IDLE;
          last_grant_next = 1'b1;
        end else if (!req1) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // last_grant resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: behavioural RAM with programmable stall, scoreboard of
// expected completions, and directed transfers, ties and a mid-transfer reset.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [31:0] m0_address = '0, m1_address = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;

  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;

  logic        fp_m0_waitrequest, fp_m1_waitrequest;
  logic [31:0] fp_m0_readdata, fp_m1_readdata;
  logic [31:0] fp_s_address, fp_s_writedata;
  logic        fp_s_read, fp_s_write;
  logic [3:0]  fp_s_byteenable;
  logic [1:0]  fp_grant;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          master;
    bit          rd;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mips_bus_arbiter #(.FIXED_PRIORITY(1'b0)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(grant)
  );

  // Fixed-priority instance sees the same masters and a zero-wait dummy slave.
  mips_bus_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(fp_m0_waitrequest), .m0_readdata(fp_m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(fp_m1_waitrequest), .m1_readdata(fp_m1_readdata),
    .s_address(fp_s_address), .s_read(fp_s_read), .s_write(fp_s_write),
    .s_writedata(fp_s_writedata), .s_byteenable(fp_s_byteenable),
    .s_waitrequest(1'b0), .s_readdata(32'h0),
    .grant(fp_grant)
  );

  // RAM model: stall_req wait cycles per transfer, then the access happens.
  logic [31:0] mem [0:4095];
  int stall_req = 0;
  int stall_cnt = 0;

  assign s_waitrequest = (s_read | s_write) && (stall_cnt < stall_req);
  assign s_readdata    = mem[s_address[13:2]];

  always @(posedge clk) begin
    if (s_read | s_write) begin
      if (stall_cnt < stall_req) begin
        stall_cnt <= stall_cnt + 1;
      end else begin
        stall_cnt <= 0;
        if (s_write)
          for (int b = 0; b < 4; b++)
            if (s_byteenable[b]) mem[s_address[13:2]][b*8 +: 8] <= s_writedata[b*8 +: 8];
      end
    end else begin
      stall_cnt <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input int m, input bit rd, input logic [31:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: master %0d completed with %h, nothing expected", m, data);
    end else begin
      e = sb.pop_front();
      chk("sb_master", m, e.master);
      chk("sb_kind", {31'b0, rd}, {31'b0, e.rd});
      chk(rd ? "sb_rdata" : "sb_wdata", data, e.data);
    end
  endtask

  // Monitor: a completion is the owner seeing waitrequest low with a request up.
  always @(negedge clk) begin
    if (!reset) begin
      if (grant == 2'b01 && !m0_waitrequest && (m0_read | m0_write))
        sb_pop(0, m0_read, m0_read ? m0_readdata : s_writedata);
      if (grant == 2'b10 && !m1_waitrequest && (m1_read | m1_write))
        sb_pop(1, m1_read, m1_read ? m1_readdata : s_writedata);
    end
  end

  task automatic drive(input int m, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = addr; m0_writedata = wd; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = addr; m1_writedata = wd; m1_byteenable = be;
    end
  endtask

  task automatic push(input int m, input bit rd, input logic [31:0] data);
    exp_t e;
    e.master = m; e.rd = rd; e.data = data;
    sb.push_back(e);
  endtask

  // One transfer by master m; returns the number of granted cycles.
  task automatic xfer(input int m, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be, input int stall, output int cycles);
    logic [1:0] gexp;
    logic       mw;
    bit         done;
    gexp = (m == 0) ? 2'b01 : 2'b10;
    @(posedge clk); #1;
    stall_req = stall;
    push(m, !wr, data);
    drive(m, !wr, wr, addr, wr ? data : 32'h0, be);
    @(negedge clk);
    mw = (m == 0) ? m0_waitrequest : m1_waitrequest;
    chk("arb_grant", {30'b0, grant}, 32'h0);
    chk("arb_wait", {31'b0, mw}, 32'h1);
    cycles = 0;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      mw = (m == 0) ? m0_waitrequest : m1_waitrequest;
      chk("own_grant", {30'b0, grant}, {30'b0, gexp});
      chk("wait_mirror", {31'b0, mw}, {31'b0, s_waitrequest});
      chk("s_address", s_address, addr);
      chk("s_ctrl", {30'b0, s_read, s_write}, {30'b0, !wr, wr});
      chk("s_writedata", s_writedata, wr ? data : 32'h0);
      chk("s_byteenable", {28'b0, s_byteenable}, {28'b0, be});
      cycles++;
      if (!mw) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL xfer_timeout: master %0d no completion in 30 cycles", m);
    end
    @(posedge clk); #1;
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("gap_grant", {30'b0, grant}, 32'h0);
    chk("gap_sread", {31'b0, s_read}, 32'h0);
  endtask

  // Both masters read continuously: m0 from 0xBFC00000, m1 from 0x400.
  // Cycle k: 0 = arbitration, odd = grant alternating 01/10, even = gap.
  task automatic tie(input int n);
    logic [1:0] rr_exp, fp_exp;
    @(posedge clk); #1;
    stall_req = 0;
    for (int k = 1; k < n; k += 2) begin
      if (((k - 1) / 2) % 2 == 0) push(0, 1'b1, 32'h3C03BFC0);
      else                        push(1, 1'b1, 32'h1234BEEF);
    end
    drive(0, 1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 32'h00000400, 32'h0, 4'hF);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        rr_exp = 2'b00; fp_exp = 2'b00;
      end else begin
        rr_exp = (((k - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10;
        fp_exp = 2'b01;
      end
      chk("tie_rr_grant", {30'b0, grant}, {30'b0, rr_exp});
      chk("tie_fp_grant", {30'b0, fp_grant}, {30'b0, fp_exp});
      if (rr_exp == 2'b01) chk("tie_m1_wait", {31'b0, m1_waitrequest}, 32'h1);
      if (rr_exp == 2'b10) chk("tie_m0_wait", {31'b0, m0_waitrequest}, 32'h1);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int cyc;
    #1;
    chk("rst_grant", {30'b0, grant}, 32'h0);
    chk("rst_waits", {30'b0, m0_waitrequest, m1_waitrequest}, 32'h3);
    chk("rst_sctrl", {30'b0, s_read, s_write}, 32'h0);
    chk("rst_saddr", s_address, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Preload through the debug port.
    xfer(1, 1'b1, 32'hBFC00000, 32'h3C03BFC0, 4'hF, 0, cyc);
    xfer(1, 1'b1, 32'h00000400, 32'h12345678, 4'hF, 0, cyc);

    xfer(0, 1'b0, 32'hBFC00000, 32'h3C03BFC0, 4'hF, 0, cyc);
    chk("single_read_cycles", cyc, 32'd1);

    xfer(1, 1'b1, 32'h00000400, 32'hDEADBEEF, 4'b0011, 3, cyc);
    chk("stall_cycles", cyc, 32'd4);
    xfer(0, 1'b0, 32'h00000400, 32'h1234BEEF, 4'hF, 0, cyc);

    pulse_reset();
    tie(9);

    // m0 wins last so an unreset tie would go to m1; reset must restore m0 priority.
    xfer(0, 1'b0, 32'hBFC00000, 32'h3C03BFC0, 4'hF, 0, cyc);
    @(posedge clk); #1;
    stall_req = 10;
    drive(1, 1'b0, 1'b1, 32'h00000800, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_grant", {30'b0, grant}, 32'h2);
    chk("pre_rst_swrite", {31'b0, s_write}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_swrite", {31'b0, s_write}, 32'h0);
    chk("async_grant", {30'b0, grant}, 32'h0);
    chk("async_waits", {30'b0, m0_waitrequest, m1_waitrequest}, 32'h3);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    stall_req = 0;
    reset = 1'b0;
    tie(5);

    // CPU-style m0-only traffic, including a write and its read-back.
    xfer(0, 1'b0, 32'hBFC00000, 32'h3C03BFC0, 4'hF, 1, cyc);
    xfer(0, 1'b1, 32'h00000800, 32'h00000000, 4'hF, 0, cyc);
    xfer(0, 1'b0, 32'h00000800, 32'h00000000, 4'hF, 2, cyc);
    chk("cpu_stall_cycles", cyc, 32'd3);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
